mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_rr.sv | 19 +
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and widths for the two-requester memory arbiter.
package mem_arbiter_pkg;

    localparam int ADDR_W  = 10;
    localparam int WDATA_W = 8;
    localparam int RDATA_W = 32;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
    typedef enum logic {OP_RD, OP_WR} op_t;

    // Transaction latched when a requester wins arbitration.
    typedef struct packed {
        op_t                op;
        logic [ADDR_W-1:0]  addr;
        logic [WDATA_W-1:0] wdata;
    } txn_t;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-input round-robin grant: on a tie the requester not granted last wins.
module rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       grant_o,
    output logic       valid_o
);

    always_comb begin
        valid_o = |req_i;
        grant_o = 1'b0;
        if (&req_i) begin
            grant_o = ~last_grant_i;
        end else begin
            grant_o = req_i[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: round-robin grant, one outstanding memory
// transaction at a time, and a WAIT timeout that completes with an error pulse.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               r0_rd_req,
    input  logic               r1_rd_req,
    input  logic               r0_wr_req,
    input  logic               r1_wr_req,
    input  logic [ADDR_W-1:0]  r0_addr,
    input  logic [ADDR_W-1:0]  r1_addr,
    input  logic [WDATA_W-1:0] r0_wdata,
    input  logic [WDATA_W-1:0] r1_wdata,
    output logic [RDATA_W-1:0] r0_rdata,
    output logic [RDATA_W-1:0] r1_rdata,
    output logic               r0_rd_ready,
    output logic               r1_rd_ready,
    output logic               r0_wr_ready,
    output logic               r1_wr_ready,
    output logic               r0_err,
    output logic               r1_err,
    output logic               cache_read_req_to_mem,
    output logic               cache_write_req_to_mem,
    output logic [ADDR_W-1:0]  AddressBus,
    output logic [WDATA_W-1:0] dInputBus,
    input  logic [RDATA_W-1:0] dOutputBus,
    input  logic               memoryRR,
    input  logic               memoryWR
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    arb_state_t              state_q, state_d;
    txn_t                    txn_q, txn_d;
    logic                    gnt_q, gnt_d;
    logic                    last_q, last_d;
    logic                    err_q, err_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [1:0][RDATA_W-1:0] rdata_q, rdata_d;

    logic [1:0]              rd_req, any_req;
    logic [1:0][ADDR_W-1:0]  addr;
    logic [1:0][WDATA_W-1:0] wdata;
    logic                    win, win_vld;

    assign rd_req  = {r1_rd_req, r0_rd_req};
    assign any_req = rd_req | {r1_wr_req, r0_wr_req};
    assign addr    = {r1_addr, r0_addr};
    assign wdata   = {r1_wdata, r0_wdata};

    rr_arbiter2 u_rr (
        .req_i        (any_req),
        .last_grant_i (last_q),
        .grant_o      (win),
        .valid_o      (win_vld)
    );

    always_comb begin
        state_d = state_q;
        txn_d   = txn_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                // A requester holding both rd and wr gets its read first.
                if (win_vld) begin
                    gnt_d       = win;
                    txn_d.op    = rd_req[win] ? OP_RD : OP_WR;
                    txn_d.addr  = addr[win];
                    txn_d.wdata = wdata[win];
                    err_d       = 1'b0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (txn_q.op == OP_RD && memoryRR) begin
                    rdata_d[gnt_q] = dOutputBus;
                    state_d        = RESP;
                end else if (txn_q.op == OP_WR && memoryWR) begin
                    state_d = RESP;
                end else if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                    if (txn_q.op == OP_RD) rdata_d[gnt_q] = '0;
                end
            end
            RESP: begin
                last_d  = gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            txn_q   <= '0;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            txn_q   <= txn_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        cache_read_req_to_mem  = (state_q == ISSUE) && (txn_q.op == OP_RD);
        cache_write_req_to_mem = (state_q == ISSUE) && (txn_q.op == OP_WR);
        AddressBus  = (state_q == IDLE) ? '0 : txn_q.addr;
        dInputBus   = (state_q == IDLE) ? '0 : txn_q.wdata;
        r0_rd_ready = (state_q == RESP) && !gnt_q && (txn_q.op == OP_RD);
        r1_rd_ready = (state_q == RESP) &&  gnt_q && (txn_q.op == OP_RD);
        r0_wr_ready = (state_q == RESP) && !gnt_q && (txn_q.op == OP_WR);
        r1_wr_ready = (state_q == RESP) &&  gnt_q && (txn_q.op == OP_WR);
        r0_err      = (state_q == RESP) && !gnt_q && err_q;
        r1_err      = (state_q == RESP) &&  gnt_q && err_q;
        r0_rdata    = rdata_q[0];
        r1_rdata    = rdata_q[1];
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run, checked
// against a transaction-level model (who, op, address, cycle the ready is due).
module tb_mem_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0_rd_req, r1_rd_req, r0_wr_req, r1_wr_req;
    logic [9:0]  r0_addr, r1_addr;
    logic [7:0]  r0_wdata, r1_wdata;
    logic [31:0] r0_rdata, r1_rdata;
    logic        r0_rd_ready, r1_rd_ready, r0_wr_ready, r1_wr_ready, r0_err, r1_err;
    logic        cache_read_req_to_mem, cache_write_req_to_mem;
    logic [9:0]  AddressBus;
    logic [7:0]  dInputBus;
    logic [31:0] dOutputBus;
    logic        memoryRR, memoryWR;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .r0_rd_req(r0_rd_req), .r1_rd_req(r1_rd_req),
        .r0_wr_req(r0_wr_req), .r1_wr_req(r1_wr_req),
        .r0_addr(r0_addr), .r1_addr(r1_addr),
        .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
        .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
        .r0_rd_ready(r0_rd_ready), .r1_rd_ready(r1_rd_ready),
        .r0_wr_ready(r0_wr_ready), .r1_wr_ready(r1_wr_ready),
        .r0_err(r0_err), .r1_err(r1_err),
        .cache_read_req_to_mem(cache_read_req_to_mem),
        .cache_write_req_to_mem(cache_write_req_to_mem),
        .AddressBus(AddressBus), .dInputBus(dInputBus),
        .dOutputBus(dOutputBus), .memoryRR(memoryRR), .memoryWR(memoryWR)
    );

    int checks = 0, errors = 0, cyc = 0;

    // Requester and memory-responder stimulus state
    logic [1:0]  h_rd, h_wr;
    logic [9:0]  ra [2];
    logic [7:0]  rw [2];
    int          drop_rd_at [2], drop_wr_at [2];
    bit          rand_req, noise, sticky, use_fixed;
    int          mem_mode, req_pct, resp_cyc, extra_rr_cyc, req_cyc;
    logic [31:0] fixed_data;

    // Reference model: one outstanding transaction and its expected completion
    bit          m_busy, nx_issue, m_idle_now, m_who, m_rd, m_err, m_last;
    logic [9:0]  m_addr;
    logic [7:0]  m_wdata;
    logic [31:0] m_data;
    logic [31:0] m_rdata [2];
    int          m_issue, m_due, done_cyc;
    int          grant_log[$], op_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic put_ports();
        r0_rd_req = h_rd[0]; r1_rd_req = h_rd[1];
        r0_wr_req = h_wr[0]; r1_wr_req = h_wr[1];
        r0_addr = ra[0]; r1_addr = ra[1];
        r0_wdata = rw[0]; r1_wdata = rw[1];
    endtask

    task automatic check_reset_outs();
        chk("rst_outs", 32'({cache_read_req_to_mem, cache_write_req_to_mem, r0_rd_ready,
            r1_rd_ready, r0_wr_ready, r1_wr_ready, r0_err, r1_err, AddressBus, dInputBus}), 32'd0);
        chk("rst_r0_rdata", r0_rdata, 32'd0);
        chk("rst_r1_rdata", r1_rdata, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        h_rd = '0; h_wr = '0;
        put_ports();
        memoryRR = 1'b0; memoryWR = 1'b0; dOutputBus = $urandom();
        m_busy = 0; nx_issue = 0; m_last = 1'b1;
        m_rdata[0] = '0; m_rdata[1] = '0;
        resp_cyc = -1; extra_rr_cyc = -1;
        for (int r = 0; r < 2; r++) begin drop_rd_at[r] = -1; drop_wr_at[r] = -1; end
        grant_log.delete(); op_log.delete();
        #1;
        check_reset_outs();
        repeat (2) begin @(posedge clk); #1; cyc++; end
        check_reset_outs();
        rst = 1'b1;
    endtask

    task automatic observe();
        bit issue_now, due_now;
        logic [5:0] exp_rdy;
        int lat, r;
        issue_now  = nx_issue;
        nx_issue   = 0;
        m_idle_now = !m_busy && !issue_now;
        if (issue_now) begin
            m_busy  = 1;
            m_issue = cyc;
            grant_log.push_back(int'(m_who));
            if (mem_mode >= 0) lat = mem_mode;
            else if (mem_mode == -2) lat = -1;
            else begin
                r   = int'($urandom_range(0, 11));
                lat = (r == 0) ? -1 : (r == 1) ? 15 : r - 2;
            end
            m_data = use_fixed ? fixed_data : $urandom();
            if (lat < 0) begin
                m_err = 1; m_due = cyc + TO + 1; resp_cyc = -1;
            end else begin
                m_err = 0; m_due = cyc + lat + 2; resp_cyc = cyc + lat + 1;
            end
        end
        chk("rd_strobe", 32'(cache_read_req_to_mem), 32'(issue_now && m_rd));
        chk("wr_strobe", 32'(cache_write_req_to_mem), 32'(issue_now && !m_rd));
        chk("addr_bus", 32'(AddressBus), m_busy ? 32'(m_addr) : 32'd0);
        chk("wdata_bus", 32'(dInputBus), m_busy ? 32'(m_wdata) : 32'd0);
        due_now = m_busy && (cyc == m_due);
        exp_rdy = '0;
        if (due_now) begin
            if (m_rd) m_rdata[m_who] = m_err ? 32'd0 : m_data;
            exp_rdy[(m_rd ? 0 : 2) + int'(m_who)] = 1'b1;
            if (m_err) exp_rdy[4 + int'(m_who)] = 1'b1;
        end
        chk("ready_err", 32'({r1_err, r0_err, r1_wr_ready, r0_wr_ready, r1_rd_ready, r0_rd_ready}),
            32'(exp_rdy));
        chk("r0_rdata", r0_rdata, m_rdata[0]);
        chk("r1_rdata", r1_rdata, m_rdata[1]);
        if (due_now) begin
            m_busy = 0;
            m_last = m_who;
            op_log.push_back(int'(m_rd));
            done_cyc = cyc;
            if (m_rd) drop_rd_at[m_who] = cyc + 1;
            else      drop_wr_at[m_who] = cyc + 1;
        end
    endtask

    task automatic drive();
        bit wait_win;
        int k;
        for (int r = 0; r < 2; r++) begin
            if (!sticky && drop_rd_at[r] == cyc) h_rd[r] = 1'b0;
            if (!sticky && drop_wr_at[r] == cyc) h_wr[r] = 1'b0;
            if (rand_req && !h_rd[r] && !h_wr[r] && drop_rd_at[r] != cyc && drop_wr_at[r] != cyc
                && int'($urandom_range(0, 99)) < req_pct) begin
                k = int'($urandom_range(0, 5));
                h_rd[r] = (k <= 2) || (k == 5);
                h_wr[r] = (k >= 3);
                ra[r] = 10'($urandom()); rw[r] = 8'($urandom());
            end else if (rand_req && $urandom_range(0, 3) == 0) begin
                ra[r] = 10'($urandom()); rw[r] = 8'($urandom());
            end
        end
        put_ports();
        memoryRR = 1'b0; memoryWR = 1'b0; dOutputBus = $urandom();
        wait_win = m_busy && cyc > m_issue && cyc < m_due;
        if (cyc == resp_cyc) begin
            memoryRR = m_rd; memoryWR = !m_rd; dOutputBus = m_data;
        end else if (cyc == extra_rr_cyc) begin
            memoryRR = 1'b1;
        end else if (noise && $urandom_range(0, 9) == 0) begin
            // Inside WAIT only the wrong completion type may appear.
            if (wait_win) begin
                memoryRR = !m_rd; memoryWR = m_rd;
            end else begin
                memoryRR = 1'($urandom_range(0, 1)); memoryWR = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic plan();
        logic [1:0] pend;
        pend = h_rd | h_wr;
        if (m_idle_now && pend != 2'b00) begin
            nx_issue = 1;
            m_who    = (pend == 2'b11) ? !m_last : pend[1];
            m_rd     = h_rd[m_who];
            m_addr   = ra[m_who];
            m_wdata  = rw[m_who];
        end
    endtask

    task automatic step();
        @(posedge clk); #1; cyc++;
        observe();
        drive();
        plan();
    endtask

    task automatic run_until(input int n, input int budget, input string tag);
        int k = 0;
        int target = op_log.size() + n;
        while (op_log.size() < target && k < budget) begin step(); k++; end
        chk(tag, 32'(op_log.size() >= target), 32'd1);
    endtask

    initial begin
        int k;
        sticky = 0; rand_req = 0; noise = 0; use_fixed = 0; mem_mode = -1; req_pct = 30;
        fixed_data = '0; done_cyc = 0; req_cyc = 0;
        m_who = 0; m_rd = 0; m_err = 0; m_addr = '0; m_wdata = '0; m_data = '0;
        m_issue = 0; m_due = 0;
        ra[0] = '0; ra[1] = '0; rw[0] = '0; rw[1] = '0;
        h_rd = '0; h_wr = '0;
        put_ports();
        memoryRR = 1'b0; memoryWR = 1'b0; dOutputBus = '0;
        #2;
        do_reset();

        // r0 read of 0x0A4, memory answers 2 cycles after the strobe
        mem_mode = 2; use_fixed = 1; fixed_data = 32'hDEADBEEF;
        h_rd[0] = 1'b1; ra[0] = 10'h0A4; rw[0] = 8'h11;
        req_cyc = cyc + 1;
        run_until(1, 40, "t1_done");
        chk("t1_latency", 32'(done_cyc - req_cyc), 32'd5);
        chk("t1_rdata", r0_rdata, 32'hDEADBEEF);
        chk("t1_grants", 32'(grant_log.size()), 32'd1);
        use_fixed = 0;

        // simultaneous r0 read and r1 write from reset
        do_reset();
        mem_mode = 1;
        h_rd[0] = 1'b1; ra[0] = 10'h010; rw[0] = 8'h00;
        h_wr[1] = 1'b1; ra[1] = 10'h3FF; rw[1] = 8'h5A;
        run_until(2, 60, "t2_done");
        chk("t2_first", 32'(at(grant_log, 0)), 32'd0);
        chk("t2_second", 32'(at(grant_log, 1)), 32'd1);
        chk("t2_second_op_wr", 32'(at(op_log, 1)), 32'd0);

        // both requesters held continuously: grants alternate
        do_reset();
        sticky = 1; mem_mode = 0;
        h_rd = 2'b11; ra[0] = 10'h111; ra[1] = 10'h222; rw[0] = 8'h33; rw[1] = 8'h44;
        run_until(4, 80, "t3_done");
        for (int i = 0; i < 4; i++) chk($sformatf("t3_grant%0d", i), 32'(at(grant_log, i)), 32'(i % 2));
        sticky = 0; h_rd = '0;
        repeat (3) step();

        // r1 read, memory silent: timeout after TO cycles in WAIT
        mem_mode = -2;
        h_rd[1] = 1'b1; ra[1] = 10'h155;
        run_until(1, 40, "t4_done");
        chk("t4_wait_len", 32'(done_cyc - m_issue), 32'(TO + 1));
        chk("t4_err", 32'({r1_err, r1_rd_ready}), 32'd3);
        chk("t4_rdata", r1_rdata, 32'd0);
        repeat (3) step();

        // reset while in WAIT, late memoryRR after release
        mem_mode = 5;
        h_rd[0] = 1'b1; ra[0] = 10'h2C3;
        k = 0;
        while (!(m_busy && cyc == m_issue + 2) && k < 20) begin step(); k++; end
        chk("t5_addr_in_wait", 32'(AddressBus), 32'h2C3);
        do_reset();
        extra_rr_cyc = cyc + 1;
        repeat (6) step();
        chk("t5_no_ready", 32'(op_log.size()), 32'd0);
        chk("t5_addr_idle", 32'(AddressBus), 32'd0);

        // r0 asserts rd and wr together: read first, then write
        mem_mode = 1;
        h_rd[0] = 1'b1; h_wr[0] = 1'b1; ra[0] = 10'h0F0; rw[0] = 8'hC3;
        run_until(2, 40, "t6_done");
        chk("t6_op0_rd", 32'(at(op_log, 0)), 32'd1);
        chk("t6_op1_wr", 32'(at(op_log, 1)), 32'd0);
        chk("t6_who1", 32'(at(grant_log, 1)), 32'd0);
        repeat (3) step();

        // randomized traffic with spurious completion pulses
        op_log.delete();
        rand_req = 1; noise = 1; mem_mode = -1; req_pct = 40;
        repeat (3000) step();
        chk("rand_progress", 32'(op_log.size() > 50), 32'd1);
        rand_req = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
